fft16_ofdm_core: RTL and testbench

- 16-point radix-2 decimation-in-time FFT core for the OFDM demo path.
- Collects 16 real 8-bit samples from the UART receive side, runs the transform, and presents 16 complex results in parallel to the byte-serialising transmit logic.
- Signals completion with a one-cycle done pulse.

---
 rtl/fft16_pkg.sv | 28 ++
 rtl/fft16_ofdm_core_butterfly.sv | 54 +++++
 rtl/fft16_ofdm_core.sv | 187 ++++++++++++++++++
 tb/tb_fft16_ofdm_core.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, twiddle tables, FSM state type and bit-reverse helper for the
// 16-point FFT core.
package fft16_pkg;

  localparam int FFT_WORD_SIZE   = 16;
  localparam int FFT_DATA_LENGTH = 8;
  localparam int FFT_FRACTION    = 8;
  localparam int FFT_STAGES      = 4;

  // W16^k = cos - j*sin, scaled by 2^FRACTION, k = 0..7
  localparam logic signed [FFT_WORD_SIZE-1:0] TW_COS [0:7] = '{
    16'sd256, 16'sd237, 16'sd181, 16'sd98, 16'sd0, -16'sd98, -16'sd181, -16'sd237
  };
  localparam logic signed [FFT_WORD_SIZE-1:0] TW_SIN [0:7] = '{
    16'sd0, 16'sd98, 16'sd181, 16'sd237, 16'sd256, 16'sd237, 16'sd181, 16'sd98
  };

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } fft_state_e;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_ofdm_core_butterfly.sv
// Combinational radix-2 butterfly: t = b*W, a' = (a+t)>>>1, b' = (a-t)>>>1.
// Build option FFT_ROUND_EN switches truncation to round-half-up.
module fft_butterfly
  import fft16_pkg::*;
#(
  parameter int W = FFT_WORD_SIZE,
  parameter int F = FFT_FRACTION
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic signed [W-1:0] w_cos,
  input  logic signed [W-1:0] w_sin,
  output logic signed [W-1:0] y0_re,
  output logic signed [W-1:0] y0_im,
  output logic signed [W-1:0] y1_re,
  output logic signed [W-1:0] y1_im
);

`ifdef FFT_ROUND_EN
  localparam logic signed [2*W:0] MUL_RND  = $signed({{(2*W){1'b0}}, 1'b1}) <<< (F-1);
  localparam logic signed [W:0]   HALF_RND = $signed({{W{1'b0}}, 1'b1});
`else
  localparam logic signed [2*W:0] MUL_RND  = $signed({(2*W+1){1'b0}});
  localparam logic signed [W:0]   HALF_RND = $signed({(W+1){1'b0}});
`endif

  logic signed [2*W-1:0] p_rc_s, p_is_s, p_ic_s, p_rs_s;
  logic signed [2*W:0]   t_re_full_s, t_im_full_s;
  logic signed [W-1:0]   t_re_s, t_im_s;
  logic signed [W:0]     s_re_s, s_im_s, d_re_s, d_im_s;

  // (br + j*bi)(c - j*s) = (br*c + bi*s) + j(bi*c - br*s)
  always_comb begin
    p_rc_s      = b_re * w_cos;
    p_is_s      = b_im * w_sin;
    p_ic_s      = b_im * w_cos;
    p_rs_s      = b_re * w_sin;
    t_re_full_s = p_rc_s + p_is_s + MUL_RND;
    t_im_full_s = p_ic_s - p_rs_s + MUL_RND;
    t_re_s      = W'(t_re_full_s >>> F);
    t_im_s      = W'(t_im_full_s >>> F);
    s_re_s      = a_re + t_re_s + HALF_RND;
    s_im_s      = a_im + t_im_s + HALF_RND;
    d_re_s      = a_re - t_re_s + HALF_RND;
    d_im_s      = a_im - t_im_s + HALF_RND;
    y0_re       = W'(s_re_s >>> 1'b1);
    y0_im       = W'(s_im_s >>> 1'b1);
    y1_re       = W'(d_re_s >>> 1'b1);
    y1_im       = W'(d_im_s >>> 1'b1);
  end

endmodule

// File: rtl/fft16_ofdm_core.sv
// 16-point radix-2 DIT FFT: loads 16 real bytes, runs 32 time-shared butterflies,
// presents bins in parallel with a done pulse. Optional rounding: FFT_ROUND_EN.
module fft16_ofdm_core
  import fft16_pkg::*;
#(
  parameter int WORD_SIZE   = FFT_WORD_SIZE,
  parameter int DATA_LENGTH = FFT_DATA_LENGTH,
  parameter int FRACTION    = FFT_FRACTION,
  parameter int STAGES      = FFT_STAGES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_LENGTH-1:0] i_byte,
  input  logic                   i_byte_valid,
  output logic [WORD_SIZE-1:0]   out0_re,  output logic [WORD_SIZE-1:0] out0_im,
  output logic [WORD_SIZE-1:0]   out1_re,  output logic [WORD_SIZE-1:0] out1_im,
  output logic [WORD_SIZE-1:0]   out2_re,  output logic [WORD_SIZE-1:0] out2_im,
  output logic [WORD_SIZE-1:0]   out3_re,  output logic [WORD_SIZE-1:0] out3_im,
  output logic [WORD_SIZE-1:0]   out4_re,  output logic [WORD_SIZE-1:0] out4_im,
  output logic [WORD_SIZE-1:0]   out5_re,  output logic [WORD_SIZE-1:0] out5_im,
  output logic [WORD_SIZE-1:0]   out6_re,  output logic [WORD_SIZE-1:0] out6_im,
  output logic [WORD_SIZE-1:0]   out7_re,  output logic [WORD_SIZE-1:0] out7_im,
  output logic [WORD_SIZE-1:0]   out8_re,  output logic [WORD_SIZE-1:0] out8_im,
  output logic [WORD_SIZE-1:0]   out9_re,  output logic [WORD_SIZE-1:0] out9_im,
  output logic [WORD_SIZE-1:0]   out10_re, output logic [WORD_SIZE-1:0] out10_im,
  output logic [WORD_SIZE-1:0]   out11_re, output logic [WORD_SIZE-1:0] out11_im,
  output logic [WORD_SIZE-1:0]   out12_re, output logic [WORD_SIZE-1:0] out12_im,
  output logic [WORD_SIZE-1:0]   out13_re, output logic [WORD_SIZE-1:0] out13_im,
  output logic [WORD_SIZE-1:0]   out14_re, output logic [WORD_SIZE-1:0] out14_im,
  output logic [WORD_SIZE-1:0]   out15_re, output logic [WORD_SIZE-1:0] out15_im,
  output logic                   o_FFT_cycle_done
);

  localparam logic [4:0] STEP_LAST = 5'(STAGES * 8 - 1);

  fft_state_e state_r, state_next_s;
  logic [3:0] cnt_r;
  logic [4:0] step_r;
  logic       done_r;
  logic signed [WORD_SIZE-1:0] ram_re_r [16];
  logic signed [WORD_SIZE-1:0] ram_im_r [16];
  logic signed [WORD_SIZE-1:0] out_re_r [16];
  logic signed [WORD_SIZE-1:0] out_im_r [16];

  logic [3:0] a_idx_s, b_idx_s;
  logic [2:0] tw_k_s;
  logic signed [WORD_SIZE-1:0] sample_s;
  logic signed [WORD_SIZE-1:0] y0_re_s, y0_im_s, y1_re_s, y1_im_s;

  assign sample_s = WORD_SIZE'($signed(i_byte)) <<< FRACTION;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD: begin
        if (i_byte_valid && (cnt_r == 4'd15)) state_next_s = COMPUTE;
        else                                  state_next_s = LOAD;
      end
      COMPUTE: begin
        if (step_r == STEP_LAST) state_next_s = DONE;
        else                     state_next_s = COMPUTE;
      end
      DONE:    state_next_s = LOAD;
      default: state_next_s = LOAD;
    endcase
  end

  // Butterfly operand addresses: step_r = {stage, butterfly}; span doubles per stage
  always_comb begin
    a_idx_s = 4'd0;
    b_idx_s = 4'd0;
    tw_k_s  = 3'd0;
    case (step_r[4:3])
      2'd0: begin
        a_idx_s = {step_r[2:0], 1'b0};
        b_idx_s = {step_r[2:0], 1'b1};
        tw_k_s  = 3'd0;
      end
      2'd1: begin
        a_idx_s = {step_r[2:1], 1'b0, step_r[0]};
        b_idx_s = {step_r[2:1], 1'b1, step_r[0]};
        tw_k_s  = {step_r[0], 2'b00};
      end
      2'd2: begin
        a_idx_s = {step_r[2], 1'b0, step_r[1:0]};
        b_idx_s = {step_r[2], 1'b1, step_r[1:0]};
        tw_k_s  = {step_r[1:0], 1'b0};
      end
      2'd3: begin
        a_idx_s = {1'b0, step_r[2:0]};
        b_idx_s = {1'b1, step_r[2:0]};
        tw_k_s  = step_r[2:0];
      end
      default: begin
        a_idx_s = 4'd0;
        b_idx_s = 4'd0;
        tw_k_s  = 3'd0;
      end
    endcase
  end

  fft_butterfly #(.W(WORD_SIZE), .F(FRACTION)) u_bfly (
    .a_re  (ram_re_r[a_idx_s]),
    .a_im  (ram_im_r[a_idx_s]),
    .b_re  (ram_re_r[b_idx_s]),
    .b_im  (ram_im_r[b_idx_s]),
    .w_cos (TW_COS[tw_k_s]),
    .w_sin (TW_SIN[tw_k_s]),
    .y0_re (y0_re_s),
    .y0_im (y0_im_s),
    .y1_re (y1_re_s),
    .y1_im (y1_im_s)
  );

  // Working RAM, counters and registered result bank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        ram_re_r[i] <= '0;
        ram_im_r[i] <= '0;
        out_re_r[i] <= '0;
        out_im_r[i] <= '0;
      end
      cnt_r  <= 4'd0;
      step_r <= 5'd0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (i_byte_valid) begin
            ram_re_r[bitrev4(cnt_r)] <= sample_s;
            ram_im_r[bitrev4(cnt_r)] <= '0;
            cnt_r <= cnt_r + 4'd1;
          end
        end
        COMPUTE: begin
          ram_re_r[a_idx_s] <= y0_re_s;
          ram_im_r[a_idx_s] <= y0_im_s;
          ram_re_r[b_idx_s] <= y1_re_s;
          ram_im_r[b_idx_s] <= y1_im_s;
          step_r <= step_r + 5'd1;
        end
        DONE: begin
          out_re_r <= ram_re_r;
          out_im_r <= ram_im_r;
          done_r   <= 1'b1;
          cnt_r    <= 4'd0;
          step_r   <= 5'd0;
        end
        default: begin
          cnt_r  <= 4'd0;
          step_r <= 5'd0;
        end
      endcase
    end
  end

  assign o_FFT_cycle_done = done_r;
  assign out0_re  = out_re_r[0];   assign out0_im  = out_im_r[0];
  assign out1_re  = out_re_r[1];   assign out1_im  = out_im_r[1];
  assign out2_re  = out_re_r[2];   assign out2_im  = out_im_r[2];
  assign out3_re  = out_re_r[3];   assign out3_im  = out_im_r[3];
  assign out4_re  = out_re_r[4];   assign out4_im  = out_im_r[4];
  assign out5_re  = out_re_r[5];   assign out5_im  = out_im_r[5];
  assign out6_re  = out_re_r[6];   assign out6_im  = out_im_r[6];
  assign out7_re  = out_re_r[7];   assign out7_im  = out_im_r[7];
  assign out8_re  = out_re_r[8];   assign out8_im  = out_im_r[8];
  assign out9_re  = out_re_r[9];   assign out9_im  = out_im_r[9];
  assign out10_re = out_re_r[10];  assign out10_im = out_im_r[10];
  assign out11_re = out_re_r[11];  assign out11_im = out_im_r[11];
  assign out12_re = out_re_r[12];  assign out12_im = out_im_r[12];
  assign out13_re = out_re_r[13];  assign out13_im = out_im_r[13];
  assign out14_re = out_re_r[14];  assign out14_im = out_im_r[14];
  assign out15_re = out_re_r[15];  assign out15_im = out_im_r[15];

endmodule

// File: tb/tb_fft16_ofdm_core.sv
// Directed-vector bench for fft16_ofdm_core: impulse, DC, Nyquist, ignored strobes,
// reset mid-load and result hold between frames.
module tb_fft16_ofdm_core;

  localparam int M_IMP  = 0;
  localparam int M_DC   = 1;
  localparam int M_NYQ  = 2;
  localparam int M_ZERO = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic [15:0] o_re [16];
  logic [15:0] o_im [16];
  logic        o_done;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 i_clk = ~i_clk;

  fft16_ofdm_core dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .out0_re(o_re[0]),   .out0_im(o_im[0]),   .out1_re(o_re[1]),   .out1_im(o_im[1]),
    .out2_re(o_re[2]),   .out2_im(o_im[2]),   .out3_re(o_re[3]),   .out3_im(o_im[3]),
    .out4_re(o_re[4]),   .out4_im(o_im[4]),   .out5_re(o_re[5]),   .out5_im(o_im[5]),
    .out6_re(o_re[6]),   .out6_im(o_im[6]),   .out7_re(o_re[7]),   .out7_im(o_im[7]),
    .out8_re(o_re[8]),   .out8_im(o_im[8]),   .out9_re(o_re[9]),   .out9_im(o_im[9]),
    .out10_re(o_re[10]), .out10_im(o_im[10]), .out11_re(o_re[11]), .out11_im(o_im[11]),
    .out12_re(o_re[12]), .out12_im(o_im[12]), .out13_re(o_re[13]), .out13_im(o_im[13]),
    .out14_re(o_re[14]), .out14_im(o_im[14]), .out15_re(o_re[15]), .out15_im(o_im[15]),
    .o_FFT_cycle_done(o_done)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed DFT/16 of each test frame
  function automatic logic [15:0] exp_re(input int mode, input int k);
    case (mode)
      M_IMP:   return 16'h0400;
      M_DC:    return (k == 0) ? 16'h1000 : 16'h0000;
      M_NYQ:   return (k == 8) ? 16'h2000 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input int mode, input int i);
    case (mode)
      M_IMP:   return (i == 0) ? 8'h40 : 8'h00;
      M_DC:    return 8'h10;
      M_NYQ:   return (i % 2 == 0) ? 8'h20 : 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_bins(input string tag, input int mode);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("%s_re%0d", tag, k), o_re[k], exp_re(mode, k));
      check_val($sformatf("%s_im%0d", tag, k), o_im[k], 16'h0000);
    end
  endtask

  // Loads one frame, optionally strobes 0x7F through COMPUTE/DONE, then waits for done
  task automatic run_frame(input string tag, input int mode, input bit strobe, input int prev_mode);
    int          cyc;
    bit          seen;
    logic [15:0] hold0;
    logic [15:0] hold8;
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte       = frame_byte(mode, i);
    end
    @(posedge i_clk);
    #1;
    i_byte_valid = strobe;
    i_byte       = 8'h7F;
    cyc   = 0;
    seen  = 1'b0;
    hold0 = o_re[0];
    hold8 = o_re[8];
    while (!seen && cyc < 60) begin
      hold0 = o_re[0];
      hold8 = o_re[8];
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_done) seen = 1'b1;
    end
    i_byte_valid = 1'b0;
    check_val({tag, "_done_seen"}, {15'd0, seen}, 16'd1);
    check_val({tag, "_done_lat"}, cyc[15:0], 16'd33);
    check_val({tag, "_hold_re0"}, hold0, exp_re(prev_mode, 0));
    check_val({tag, "_hold_re8"}, hold8, exp_re(prev_mode, 8));
    check_bins(tag, mode);
    @(posedge i_clk);
    #1;
    check_val({tag, "_done_pulse"}, {15'd0, o_done}, 16'd0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_val("rst_done", {15'd0, o_done}, 16'd0);
    check_bins("rst", M_ZERO);

    run_frame("imp", M_IMP, 1'b0, M_ZERO);
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) check_val("imp_single_done", {15'd0, o_done}, 16'd0);
    end
    run_frame("dc", M_DC, 1'b0, M_IMP);
    run_frame("nyq", M_NYQ, 1'b0, M_DC);
    run_frame("ign", M_IMP, 1'b1, M_NYQ);
    run_frame("dc2", M_DC, 1'b0, M_IMP);
    run_frame("b2b", M_IMP, 1'b0, M_DC);

    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte       = 8'h10;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    i_rst        = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check_val("mid_rst_done", {15'd0, o_done}, 16'd0);
    check_bins("mid_rst", M_ZERO);
    run_frame("post_rst", M_IMP, 1'b0, M_ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
